// File: rtl/axis_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module : axis_layer_sequencer
// Walks a descriptor table and issues one pixel and one weight DMA command per
// layer, then counts output packets before moving on to the next layer.
// Rev    : 1.0
// ============================================================================

module axis_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            cfg_wr_en,
    input  logic [$clog2(MAX_LAYERS)+2:0]   cfg_wr_addr,
    input  logic [ADDR_WIDTH-1:0]           cfg_wr_data,
    input  logic                            start,
    input  logic [$clog2(MAX_LAYERS):0]     num_layers,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_LAYERS)-1:0]   layer_idx,
    output logic                            m_cmd_px_valid,
    input  logic                            m_cmd_px_ready,
    output logic [ADDR_WIDTH-1:0]           m_cmd_px_addr,
    output logic [LEN_WIDTH-1:0]            m_cmd_px_len,
    output logic                            m_cmd_wt_valid,
    input  logic                            m_cmd_wt_ready,
    output logic [ADDR_WIDTH-1:0]           m_cmd_wt_addr,
    output logic [LEN_WIDTH-1:0]            m_cmd_wt_len,
    input  logic                            mon_tvalid,
    input  logic                            mon_tready,
    input  logic                            mon_tlast
);

    localparam int c_LW = $clog2(MAX_LAYERS);
    localparam int c_NW = c_LW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Descriptor table: plain registers, deliberately outside the reset domain.
    logic [ADDR_WIDTH-1:0] r_tbl_px_addr [MAX_LAYERS];
    logic [LEN_WIDTH-1:0]  r_tbl_px_len  [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0] r_tbl_wt_addr [MAX_LAYERS];
    logic [LEN_WIDTH-1:0]  r_tbl_wt_len  [MAX_LAYERS];
    logic [CNT_WIDTH-1:0]  r_tbl_n_pkts  [MAX_LAYERS];

    state_t                r_state;
    logic [c_NW-1:0]       r_num_layers;
    logic [c_LW-1:0]       r_layer;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic                  r_px_acc;
    logic                  r_wt_acc;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_px_valid;
    logic [ADDR_WIDTH-1:0] r_px_addr;
    logic [LEN_WIDTH-1:0]  r_px_len;
    logic                  r_wt_valid;
    logic [ADDR_WIDTH-1:0] r_wt_addr;
    logic [LEN_WIDTH-1:0]  r_wt_len;

    state_t                w_state_nxt;
    logic [c_NW-1:0]       w_num_nxt;
    logic [c_NW-1:0]       w_num_clamped;
    logic [c_LW-1:0]       w_layer_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_px_acc_nxt;
    logic                  w_wt_acc_nxt;
    logic                  w_px_valid_nxt;
    logic                  w_wt_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_px_addr_nxt;
    logic [LEN_WIDTH-1:0]  w_px_len_nxt;
    logic [ADDR_WIDTH-1:0] w_wt_addr_nxt;
    logic [LEN_WIDTH-1:0]  w_wt_len_nxt;
    logic                  w_load;
    logic [c_LW-1:0]       w_load_idx;
    logic                  w_px_hs;
    logic                  w_wt_hs;
    logic                  w_beat;
    logic [c_LW-1:0]       w_cfg_layer;
    logic [2:0]            w_cfg_field;

    assign w_cfg_layer = cfg_wr_addr[c_LW+2:3];
    assign w_cfg_field = cfg_wr_addr[2:0];

    always_ff @(posedge aclk) begin
        if (cfg_wr_en && !r_busy) begin
            case (w_cfg_field)
                3'd0:    r_tbl_px_addr[w_cfg_layer] <= cfg_wr_data;
                3'd1:    r_tbl_px_len[w_cfg_layer]  <= cfg_wr_data[LEN_WIDTH-1:0];
                3'd2:    r_tbl_wt_addr[w_cfg_layer] <= cfg_wr_data;
                3'd3:    r_tbl_wt_len[w_cfg_layer]  <= cfg_wr_data[LEN_WIDTH-1:0];
                3'd4:    r_tbl_n_pkts[w_cfg_layer]  <= cfg_wr_data[CNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    assign w_px_hs = r_px_valid && m_cmd_px_ready;
    assign w_wt_hs = r_wt_valid && m_cmd_wt_ready;
    assign w_beat  = mon_tvalid && mon_tready && mon_tlast &&
                     ((r_state == S_ISSUE) || (r_state == S_WAIT));
    assign w_cnt_inc = (w_beat && (r_pkt_cnt != {CNT_WIDTH{1'b1}})) ?
                       r_pkt_cnt + CNT_WIDTH'(1) : r_pkt_cnt;

    // A layer count larger than the table would never match the last index.
    assign w_num_clamped = (num_layers > c_NW'(MAX_LAYERS)) ? c_NW'(MAX_LAYERS) : num_layers;

    always_comb begin
        w_state_nxt    = r_state;
        w_num_nxt      = r_num_layers;
        w_layer_nxt    = r_layer;
        w_cnt_nxt      = r_pkt_cnt;
        w_px_acc_nxt   = r_px_acc;
        w_wt_acc_nxt   = r_wt_acc;
        w_px_valid_nxt = r_px_valid && !w_px_hs;
        w_wt_valid_nxt = r_wt_valid && !w_wt_hs;
        w_px_addr_nxt  = r_px_addr;
        w_px_len_nxt   = r_px_len;
        w_wt_addr_nxt  = r_wt_addr;
        w_wt_len_nxt   = r_wt_len;
        w_load         = 1'b0;
        w_load_idx     = r_layer;

        if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
            w_cnt_nxt = w_cnt_inc;
        end

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_layers != '0) begin
                        w_num_nxt    = w_num_clamped;
                        w_layer_nxt  = '0;
                        w_cnt_nxt    = '0;
                        w_px_acc_nxt = 1'b0;
                        w_wt_acc_nxt = 1'b0;
                        w_load       = 1'b1;
                        w_load_idx   = '0;
                        w_state_nxt  = S_ISSUE;
                    end else begin
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                w_px_acc_nxt = r_px_acc || w_px_hs;
                w_wt_acc_nxt = r_wt_acc || w_wt_hs;
                if (w_px_acc_nxt && w_wt_acc_nxt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_cnt_inc >= r_tbl_n_pkts[r_layer]) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_cnt_nxt    = '0;
                w_px_acc_nxt = 1'b0;
                w_wt_acc_nxt = 1'b0;
                if ({1'b0, r_layer} == (r_num_layers - c_NW'(1))) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_layer_nxt = r_layer + c_LW'(1);
                    w_load      = 1'b1;
                    w_load_idx  = r_layer + c_LW'(1);
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt    = S_IDLE;
            w_layer_nxt    = '0;
            w_cnt_nxt      = '0;
            w_px_acc_nxt   = 1'b0;
            w_wt_acc_nxt   = 1'b0;
            w_px_valid_nxt = 1'b0;
            w_wt_valid_nxt = 1'b0;
            w_load         = 1'b0;
        end

        if (w_load) begin
            w_px_valid_nxt = 1'b1;
            w_wt_valid_nxt = 1'b1;
            w_px_addr_nxt  = r_tbl_px_addr[w_load_idx];
            w_px_len_nxt   = r_tbl_px_len[w_load_idx];
            w_wt_addr_nxt  = r_tbl_wt_addr[w_load_idx];
            w_wt_len_nxt   = r_tbl_wt_len[w_load_idx];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_num_layers <= '0;
            r_layer      <= '0;
            r_pkt_cnt    <= '0;
            r_px_acc     <= 1'b0;
            r_wt_acc     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_px_valid   <= 1'b0;
            r_px_addr    <= '0;
            r_px_len     <= '0;
            r_wt_valid   <= 1'b0;
            r_wt_addr    <= '0;
            r_wt_len     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_num_layers <= w_num_nxt;
            r_layer      <= w_layer_nxt;
            r_pkt_cnt    <= w_cnt_nxt;
            r_px_acc     <= w_px_acc_nxt;
            r_wt_acc     <= w_wt_acc_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_px_valid   <= w_px_valid_nxt;
            r_px_addr    <= w_px_addr_nxt;
            r_px_len     <= w_px_len_nxt;
            r_wt_valid   <= w_wt_valid_nxt;
            r_wt_addr    <= w_wt_addr_nxt;
            r_wt_len     <= w_wt_len_nxt;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign layer_idx      = r_layer;
    assign m_cmd_px_valid = r_px_valid;
    assign m_cmd_px_addr  = r_px_addr;
    assign m_cmd_px_len   = r_px_len;
    assign m_cmd_wt_valid = r_wt_valid;
    assign m_cmd_wt_addr  = r_wt_addr;
    assign m_cmd_wt_len   = r_wt_len;

endmodule

`default_nettype wire

// File: tb/tb_axis_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_layer_sequencer
// Scenario bench for axis_layer_sequencer against a descriptor-level model.
// Rev    : 1.0
// ============================================================================

module tb_axis_layer_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [5:0]  cfg_wr_addr = '0;
    logic [31:0] cfg_wr_data = '0;
    logic        start = 1'b0;
    logic [3:0]  num_layers = '0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [2:0]  layer_idx;
    logic        m_cmd_px_valid, m_cmd_wt_valid;
    logic        m_cmd_px_ready = 1'b0;
    logic        m_cmd_wt_ready = 1'b0;
    logic [31:0] m_cmd_px_addr, m_cmd_wt_addr;
    logic [23:0] m_cmd_px_len, m_cmd_wt_len;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic        mon_tlast = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit rdy_rand = 1'b0;
    bit frc_px = 1'b0;
    bit frc_wt = 1'b0;

    // Descriptor model: what the host believes the table holds.
    logic [31:0] m_px_addr [8];
    logic [23:0] m_px_len  [8];
    logic [31:0] m_wt_addr [8];
    logic [23:0] m_wt_len  [8];
    logic [15:0] m_npk     [8];

    // Commands observed on the bus, in acceptance order.
    logic [31:0] q_px_addr[$];
    logic [23:0] q_px_len[$];
    int          q_px_layer[$];
    logic [31:0] q_wt_addr[$];
    logic [23:0] q_wt_len[$];
    int          q_wt_layer[$];

    axis_layer_sequencer #(
        .MAX_LAYERS (8),
        .ADDR_WIDTH (32),
        .LEN_WIDTH  (24),
        .CNT_WIDTH  (16)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .start          (start),
        .num_layers     (num_layers),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .layer_idx      (layer_idx),
        .m_cmd_px_valid (m_cmd_px_valid),
        .m_cmd_px_ready (m_cmd_px_ready),
        .m_cmd_px_addr  (m_cmd_px_addr),
        .m_cmd_px_len   (m_cmd_px_len),
        .m_cmd_wt_valid (m_cmd_wt_valid),
        .m_cmd_wt_ready (m_cmd_wt_ready),
        .m_cmd_wt_addr  (m_cmd_wt_addr),
        .m_cmd_wt_len   (m_cmd_wt_len),
        .mon_tvalid     (mon_tvalid),
        .mon_tready     (mon_tready),
        .mon_tlast      (mon_tlast)
    );

    initial forever #5 aclk = ~aclk;

    // Ready driver: random or forced, updated 2ns after each rising edge.
    initial forever begin
        @(posedge aclk);
        #2;
        if (rdy_rand) begin
            m_cmd_px_ready = 1'($urandom_range(0, 1));
            m_cmd_wt_ready = 1'($urandom_range(0, 1));
        end else begin
            m_cmd_px_ready = frc_px;
            m_cmd_wt_ready = frc_wt;
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_cmd_px_valid && m_cmd_px_ready) begin
                q_px_addr.push_back(m_cmd_px_addr);
                q_px_len.push_back(m_cmd_px_len);
                q_px_layer.push_back(int'(layer_idx));
            end
            if (m_cmd_wt_valid && m_cmd_wt_ready) begin
                q_wt_addr.push_back(m_cmd_wt_addr);
                q_wt_len.push_back(m_cmd_wt_len);
                q_wt_layer.push_back(int'(layer_idx));
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic cfg_write(input int layer, input int field, input logic [31:0] data, input bit upd);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 6'(layer * 8 + field);
        cfg_wr_data = data;
        tick();
        cfg_wr_en   = 1'b0;
        if (upd) begin
            case (field)
                0: m_px_addr[layer] = data;
                1: m_px_len[layer]  = data[23:0];
                2: m_wt_addr[layer] = data;
                3: m_wt_len[layer]  = data[23:0];
                4: m_npk[layer]     = data[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic program_layer(input int l, input logic [31:0] pa, input logic [31:0] pl,
                                 input logic [31:0] wa, input logic [31:0] wl, input logic [31:0] np);
        cfg_write(l, 0, pa, 1'b1);
        cfg_write(l, 1, pl, 1'b1);
        cfg_write(l, 2, wa, 1'b1);
        cfg_write(l, 3, wl, 1'b1);
        cfg_write(l, 4, np, 1'b1);
        cfg_write(l, 5 + int'($urandom_range(0, 2)), $urandom, 1'b1);
    endtask

    // Runs a whole sequence; early_layer gets one tlast during ISSUE,
    // abort_layer is aborted once its commands are accepted.
    task automatic run_seq(input int nl, input int early_layer, input int abort_layer);
        int base, done0, pk, guard;
        base  = q_px_addr.size();
        done0 = done_cnt;
        rdy_rand   = 1'b1;
        start      = 1'b1;
        num_layers = 4'(nl);
        tick();
        start = 1'b0;
        for (int l = 0; l < nl; l++) begin
            n_vec++;
            if ({m_cmd_px_valid, m_cmd_wt_valid, busy} !== 3'b111 || int'(layer_idx) != l) begin
                n_err++;
                $display("FAIL issue_entry L%0d: valids/busy=%b layer=%0d expected 111/%0d",
                         l, {m_cmd_px_valid, m_cmd_wt_valid, busy}, layer_idx, l);
            end
            if (l == early_layer) begin
                rdy_rand = 1'b0; frc_px = 1'b0; frc_wt = 1'b0;
                mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
                tick();
                mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
                rdy_rand = 1'b1;
            end
            guard = 0;
            while ((q_px_addr.size() < base + l + 1 || q_wt_addr.size() < base + l + 1) && guard < 300) begin
                tick();
                guard++;
            end
            n_vec++;
            if (guard >= 300) begin
                n_err++;
                $display("FAIL cmd_timeout L%0d: px=%0d wt=%0d handshakes, expected %0d",
                         l, q_px_addr.size() - base, q_wt_addr.size() - base, l + 1);
                return;
            end
            if (l == abort_layer) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                n_vec++;
                if ({busy, done, m_cmd_px_valid, m_cmd_wt_valid} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL abort_outputs: busy/done/pxv/wtv=%b expected 0000",
                             {busy, done, m_cmd_px_valid, m_cmd_wt_valid});
                end
                repeat (3) tick();
                n_vec++;
                if (done_cnt != done0 || q_px_addr.size() != base + l + 1) begin
                    n_err++;
                    $display("FAIL abort_quiet: done pulses=%0d cmds=%0d expected 0/%0d",
                             done_cnt - done0, q_px_addr.size() - base, l + 1);
                end
                return;
            end
            pk = int'(m_npk[l]) - ((l == early_layer) ? 1 : 0);
            if (pk <= 0) begin
                tick();
            end else begin
                for (int p = 0; p < pk; p++) begin
                    int nb;
                    nb = int'($urandom_range(1, 3));
                    for (int b = 0; b < nb; b++) begin
                        bit acc;
                        int g;
                        acc = 1'b0;
                        g = 0;
                        while (!acc) begin
                            mon_tvalid = 1'($urandom_range(0, 1));
                            mon_tready = 1'($urandom_range(0, 1));
                            if (g == 12) begin mon_tvalid = 1'b1; mon_tready = 1'b1; end
                            mon_tlast = (b == nb - 1);
                            acc = mon_tvalid && mon_tready;
                            tick();
                            g++;
                        end
                    end
                end
                mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
            end
            n_vec++;
            if ({busy, done, m_cmd_px_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL next_state L%0d: busy/done/pxv=%b expected 100", l,
                         {busy, done, m_cmd_px_valid});
            end
            tick();
            if (l == nl - 1) begin
                n_vec++;
                if (done !== 1'b1 || int'(layer_idx) != l) begin
                    n_err++;
                    $display("FAIL done_pulse: done=%b layer=%0d expected 1/%0d", done, layer_idx, l);
                end
                tick();
                n_vec++;
                if ({busy, done} !== 2'b00) begin
                    n_err++;
                    $display("FAIL after_done: busy/done=%b expected 00", {busy, done});
                end
            end
        end
        n_vec++;
        if (done_cnt != done0 + 1 || q_px_addr.size() != base + nl || q_wt_addr.size() != base + nl) begin
            n_err++;
            $display("FAIL seq_totals: done=%0d px=%0d wt=%0d expected 1/%0d/%0d",
                     done_cnt - done0, q_px_addr.size() - base, q_wt_addr.size() - base, nl, nl);
        end
        for (int i = 0; i < nl && base + i < q_px_addr.size() && base + i < q_wt_addr.size(); i++) begin
            n_vec++;
            if (q_px_addr[base+i] !== m_px_addr[i] || q_px_len[base+i] !== m_px_len[i] ||
                q_wt_addr[base+i] !== m_wt_addr[i] || q_wt_len[base+i] !== m_wt_len[i] ||
                q_px_layer[base+i] != i || q_wt_layer[base+i] != i) begin
                n_err++;
                $display("FAIL cmd_L%0d: px %h/%0d wt %h/%0d expected px %h/%0d wt %h/%0d", i,
                         q_px_addr[base+i], q_px_len[base+i], q_wt_addr[base+i], q_wt_len[base+i],
                         m_px_addr[i], m_px_len[i], m_wt_addr[i], m_wt_len[i]);
            end
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        n_vec++;
        if ({busy, done, layer_idx, m_cmd_px_valid, m_cmd_wt_valid} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy/done/layer/valids=%b expected 0",
                     {busy, done, layer_idx, m_cmd_px_valid, m_cmd_wt_valid});
        end
        n_vec++;
        if ({m_cmd_px_addr, m_cmd_px_len, m_cmd_wt_addr, m_cmd_wt_len} !== 112'd0) begin
            n_err++;
            $display("FAIL reset_cmd: px %h/%h wt %h/%h expected 0", m_cmd_px_addr, m_cmd_px_len,
                     m_cmd_wt_addr, m_cmd_wt_len);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_single_layer();
        int base;
        program_layer(0, 32'h1000, 256, 32'h2000, 64, 3);
        base = q_px_addr.size();
        rdy_rand = 1'b0; frc_px = 1'b1; frc_wt = 1'b1;
        tick();
        start = 1'b1; num_layers = 4'd1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({m_cmd_px_valid, m_cmd_wt_valid, busy} !== 3'b111 || m_cmd_px_addr !== 32'h1000 ||
            m_cmd_px_len !== 24'd256 || m_cmd_wt_addr !== 32'h2000 || m_cmd_wt_len !== 24'd64) begin
            n_err++;
            $display("FAIL single_cmd: v=%b px %h/%0d wt %h/%0d expected 111 1000/256 2000/64",
                     {m_cmd_px_valid, m_cmd_wt_valid, busy}, m_cmd_px_addr, m_cmd_px_len,
                     m_cmd_wt_addr, m_cmd_wt_len);
        end
        tick();
        n_vec++;
        if ({m_cmd_px_valid, m_cmd_wt_valid} !== 2'b00 || q_px_addr.size() != base + 1) begin
            n_err++;
            $display("FAIL single_valid_width: valids=%b px_hs=%0d expected 00/1",
                     {m_cmd_px_valid, m_cmd_wt_valid}, q_px_addr.size() - base);
        end
        cfg_write(0, 0, 32'hDEAD_BEEF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
            tick();
        end
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        n_vec++;
        if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL single_next: busy/done=%b expected 10", {busy, done});
        end
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL single_done: done=%b expected 1", done);
        end
        tick();
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL single_idle: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_backpressure();
        int done0;
        cfg_write(0, 4, 32'd0, 1'b1);
        done0 = done_cnt;
        rdy_rand = 1'b0; frc_px = 1'b0; frc_wt = 1'b1;
        tick();
        start = 1'b1; num_layers = 4'd1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            n_vec++;
            if (m_cmd_px_valid !== 1'b1 || m_cmd_px_addr !== m_px_addr[0] || m_cmd_px_len !== m_px_len[0] ||
                (k >= 2 && m_cmd_wt_valid !== 1'b0) || done !== 1'b0) begin
                n_err++;
                $display("FAIL bp_cycle%0d: pxv=%b addr=%h len=%0d wtv=%b done=%b expected 1 %h %0d %0d 0",
                         k, m_cmd_px_valid, m_cmd_px_addr, m_cmd_px_len, m_cmd_wt_valid, done,
                         m_px_addr[0], m_px_len[0], (k >= 2) ? 0 : 1);
            end
            if (k == 6) frc_px = 1'b1;
            tick();
        end
        n_vec++;
        if (m_cmd_px_valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: pxv=%b done=%b expected 0/0", m_cmd_px_valid, done);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL bp_early_done: done=%b expected 0", done);
        end
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_zero_pkts_done: done=%b expected 1", done);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0 || done_cnt != done0 + 1) begin
            n_err++;
            $display("FAIL bp_end: busy=%b pulses=%0d expected 0/1", busy, done_cnt - done0);
        end
    endtask

    task automatic test_three_layers();
        cfg_write(0, 4, 32'd1, 1'b1);
        program_layer(1, $urandom, $urandom_range(1, 4096), $urandom, $urandom_range(1, 4096), 2);
        program_layer(2, $urandom, $urandom_range(1, 4096), $urandom, $urandom_range(1, 4096), 1);
        run_seq(3, 1, -1);
    endtask

    task automatic test_zero_layers();
        int base, done0;
        base = q_px_addr.size();
        done0 = done_cnt;
        start = 1'b1; num_layers = 4'd0;
        tick();
        start = 1'b0;
        n_vec++;
        if ({done, busy, m_cmd_px_valid, m_cmd_wt_valid} !== 4'b1100) begin
            n_err++;
            $display("FAIL zero_done: done/busy/valids=%b expected 1100",
                     {done, busy, m_cmd_px_valid, m_cmd_wt_valid});
        end
        tick();
        n_vec++;
        if ({done, busy} !== 2'b00 || q_px_addr.size() != base || done_cnt != done0 + 1) begin
            n_err++;
            $display("FAIL zero_end: done/busy=%b cmds=%0d pulses=%0d expected 00/0/1",
                     {done, busy}, q_px_addr.size() - base, done_cnt - done0);
        end
    endtask

    task automatic test_abort();
        program_layer(1, $urandom, $urandom_range(1, 4096), $urandom, $urandom_range(1, 4096), 3);
        run_seq(3, -1, 1);
        start = 1'b1; abort = 1'b1; num_layers = 4'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        n_vec++;
        if ({busy, m_cmd_px_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_beats_start: busy/pxv=%b expected 00", {busy, m_cmd_px_valid});
        end
        run_seq(3, -1, -1);
    endtask

    task automatic test_reset_mid();
        rdy_rand = 1'b0; frc_px = 1'b0; frc_wt = 1'b0;
        tick();
        start = 1'b1; num_layers = 4'd2;
        tick();
        start = 1'b0;
        #3;
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, layer_idx, m_cmd_px_valid, m_cmd_wt_valid} !== 7'd0 ||
            {m_cmd_px_addr, m_cmd_px_len, m_cmd_wt_addr, m_cmd_wt_len} !== 112'd0) begin
            n_err++;
            $display("FAIL async_reset: ctrl=%b px %h/%h wt %h/%h expected all 0",
                     {busy, done, layer_idx, m_cmd_px_valid, m_cmd_wt_valid},
                     m_cmd_px_addr, m_cmd_px_len, m_cmd_wt_addr, m_cmd_wt_len);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        run_seq(2, -1, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int nl, e, early;
            for (int l = 0; l < 8; l++) begin
                program_layer(l, $urandom, $urandom_range(1, 24'hFFFFFF), $urandom,
                              $urandom_range(1, 24'hFFFFFF), $urandom_range(0, 3));
            end
            nl = int'($urandom_range(1, 8));
            e  = int'($urandom_range(0, nl - 1));
            early = ($urandom_range(0, 1) == 1 && m_npk[e] != 16'd0) ? e : -1;
            run_seq(nl, early, -1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_layer();
        test_backpressure();
        test_three_layers();
        test_zero_layers();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
